md_unit_param: RTL and testbench
================================

# md_unit_param

Parametrised multiply/divide unit for the E stage of the pipelined CPU. It is the successor of the fixed 32-bit MULT_DIV. It adds configurable width and latencies, multiply-accumulate ops (madd/maddu/msub/msubu), defined divide-by-zero and overflow results, and a `cancel` input for exception flush. It holds the architectural HI/LO registers and raises `busy` so the stall controller can hold mfhi/mflo and md instructions in D.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `MUL_LAT`, default 5: cycles from accepted start to commit for mult/madd/msub ops; must be ≥1.
- `DIV_LAT`, default 10: cycles from accepted start to commit for div ops; must be ≥1.

Ports (clock and reset first):
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; low forces reset state immediately.
- `start`  in  1  launch operation `op` with operands `a`, `b`.
- `op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
- `a`  in  WIDTH  rs operand, also the data source for mthi/mtlo.
- `b`  in  WIDTH  rt operand.
- `we_hi`  in  1  mthi: HI <= a.
- `we_lo`  in  1  mtlo: LO <= a.
- `cancel`  in  1  abort the in-flight operation (exception flush).
- `busy`  out  1  operation in flight; registered.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN.
- IDLE + `start` (and no `cancel`):
  - compute result from a, b, op and current {hi,lo};
  - latch it in an internal result register;
  - load counter with MUL_LAT or DIV_LAT;
  - go to RUN.
- RUN: counter decrements each cycle. When it reaches 0, commit {hi,lo} <= result and return to IDLE.
- RUN + `cancel`: go to IDLE next edge. HI/LO unchanged, result discarded.
- Multiply: 2·WIDTH product; signed for mult, unsigned for multu. {hi,lo} = product.
- madd/msub: {hi,lo} = {hi,lo} ± product. Arithmetic is modulo 2^(2·WIDTH); the carry/borrow out is dropped. Signedness of the product follows op[0] (0 signed, 1 unsigned).
- div/divu:
  - lo = quotient, truncated toward zero;
  - hi = remainder, with the sign of the dividend.
- Divide by zero (b == 0): lo = all ones, hi = a. Applies to both div and divu.
- Signed overflow (div, a = most negative value, b = −1): lo = a, hi = 0.
- `we_hi`/`we_lo` in IDLE: write the next edge. Both may assert together, and both then take `a`.
- `we_hi`/`we_lo` during RUN: ignored. Stall control guarantees they do not occur.
- `start` during RUN: ignored. It is not queued.
- `start` together with `we_hi`/`we_lo` in IDLE: `start` wins and the writes are ignored.
- `cancel` and `start` in the same cycle: `cancel` wins and `start` is ignored, in both IDLE and RUN.
- `cancel` in IDLE: no effect.

## Timing
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately. No commit happens after release.
- Start sampled at edge T0 → `busy` = 1 from T0 through T0+LAT−1 → at edge T0+LAT, HI/LO update and `busy` = 0. `busy` is therefore high for exactly LAT cycles.
- Back-to-back ops: start may be accepted at the same edge where the previous op commits only if `busy` was 0 in the sampling cycle. In practice the next start can be accepted one cycle after `busy` falls (at T0+LAT).
- A madd issued at T0+LAT uses the committed {hi,lo}.
- mthi/mtlo: HI/LO are visible on `hi`/`lo` the cycle after the write edge. There is no bypass.
- Stall control must stall md ops and mfhi/mflo while (`start` in E) or `busy`.

## Test plan
- Reset low mid-RUN with MUL_LAT=5: `busy`/`hi`/`lo` drop to 0 asynchronously. After release and 6 idle cycles, hi = lo = 0.
- mult a=0xFFFFFFFE (−2), b=3: `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu: hi=0x00000002, lo=0xFFFFFFFA.
- div a=−7, b=2, DIV_LAT=10: busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0: lo=0xFFFFFFFF, hi=7. div 0x80000000/−1: lo=0x80000000, hi=0.
- mthi 1, mtlo 0xFFFFFFFF, then maddu a=1, b=1: hi=2, lo=0. Then msub a=1, b=1: hi=1, lo=0xFFFFFFFF.
- mult 3×4 started, `cancel` on 2nd busy cycle: `busy`=0 the next cycle and HI/LO keep their prior values. Also check that start+cancel in IDLE launches nothing.
- During busy, pulse start (op=mult, a=b=9) and we_lo (a=5): both ignored; the original result commits at T0+LAT. Repeat with WIDTH=16, MUL_LAT=1: 0xFFFF·0xFFFF signed → hi=0, lo=1 after 1 cycle.

Source files
------------

// File: rtl/md_if.sv
// Handshake and result bus between the E-stage issue logic and the multiply/divide unit.
// The issuing side owns the command fields; the unit drives busy and the HI/LO registers.
interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             we_hi;
    logic             we_lo;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, we_hi, we_lo, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, we_hi, we_lo, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit holding the architectural HI/LO registers.
// The result is computed when the op is accepted and committed after a fixed latency.
module md_unit_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic  clk,
    input logic  reset,
    md_if.slave  md
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0]    MUL_CNT  = CW'(MUL_LAT);
    localparam logic [CW-1:0]    DIV_CNT  = CW'(DIV_LAT);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;

    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, product, acc, div_res, op_res;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    // Result datapath: product and accumulate wrap modulo 2^(2*WIDTH); division
    // works on magnitudes and restores the signs afterwards.
    always_comb begin
        is_signed = ~md.op[0];
        a_ext     = is_signed ? {{WIDTH{md.a[WIDTH-1]}}, md.a} : {{WIDTH{1'b0}}, md.a};
        b_ext     = is_signed ? {{WIDTH{md.b[WIDTH-1]}}, md.b} : {{WIDTH{1'b0}}, md.b};
        product   = a_ext * b_ext;
        acc       = {hi_q, lo_q};

        a_neg  = is_signed & md.a[WIDTH-1];
        b_neg  = is_signed & md.b[WIDTH-1];
        a_mag  = a_neg ? -md.a : md.a;
        b_mag  = b_neg ? -md.b : md.b;
        b_safe = (b_mag == '0) ? ONE_W : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;

        if (md.b == '0) begin
            div_res = {md.a, {WIDTH{1'b1}}};
        end else if (is_signed && md.a == MOST_NEG && md.b == {WIDTH{1'b1}}) begin
            div_res = {{WIDTH{1'b0}}, md.a};
        end else begin
            div_res = {rem, quot};
        end

        case (md.op[2:1])
            2'b00:   op_res = product;
            2'b01:   op_res = div_res;
            2'b10:   op_res = acc + product;
            default: op_res = acc - product;
        endcase
    end

    // Control: accept in IDLE, count down in RUN, commit on the last count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (md.start && !md.cancel) begin
                    res_d   = op_res;
                    cnt_d   = (md.op[2:1] == 2'b01) ? DIV_CNT : MUL_CNT;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else if (!md.start) begin
                    if (md.we_hi) hi_d = md.a;
                    if (md.we_lo) lo_d = md.a;
                end
            end
            RUN: begin
                if (md.cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q <= CNT_ONE) begin
                    {hi_d, lo_d} = res_q;
                    state_d      = IDLE;
                    cnt_d        = '0;
                    busy_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: a 32-bit default instance and a 16-bit,
// single-cycle-multiply instance share one clock and reset.
module tb_md_unit_param;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
    localparam logic [2:0] OP_MSUB  = 3'b110;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    logic clk = 1'b0;
    logic reset;
    int   errCount   = 0;
    int   checkCount = 0;

    always #5 clk = ~clk;

    md_if #(.WIDTH(32)) m1 ();
    md_if #(.WIDTH(16)) m2 ();

    md_unit_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) u1 (
        .clk(clk), .reset(reset), .md(m1)
    );
    md_unit_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(10)) u2 (
        .clk(clk), .reset(reset), .md(m2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int unit, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic st, input logic weh,
                                 input logic wel, input logic cn);
        if (unit == 0) begin
            m1.start = st; m1.op = op; m1.a = a; m1.b = b;
            m1.we_hi = weh; m1.we_lo = wel; m1.cancel = cn;
        end else begin
            m2.start = st; m2.op = op; m2.a = a[15:0]; m2.b = b[15:0];
            m2.we_hi = weh; m2.we_lo = wel; m2.cancel = cn;
        end
    endtask

    task automatic idleAll();
        applyStimulus(0, OP_MULT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, OP_MULT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] hiloOf(input int unit);
        return (unit == 0) ? {m1.hi, m1.lo} : {32'h0, m2.hi, m2.lo};
    endfunction

    function automatic logic busyOf(input int unit);
        return (unit == 0) ? m1.busy : m2.busy;
    endfunction

    // Issue one op, count the busy cycles (bounded), then check the committed HI/LO.
    task automatic runOp(input string tag, input int unit, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [63:0] exp);
        int n;
        applyStimulus(unit, op, a, b, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idleAll();
        n = 0;
        for (int i = 0; i < 40 && busyOf(unit); i++) begin
            n++;
            tick();
        end
        checkOutput({tag, "_busy"}, 64'(n), 64'(lat));
        checkOutput(tag, hiloOf(unit), exp);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        idleAll();
        #12;
        checkOutput("rst_busy", 64'(m1.busy), 64'h0);
        checkOutput("rst_hilo", hiloOf(0), 64'h0);
        checkOutput("rst_hilo16", hiloOf(1), 64'h0);
        reset = 1'b1;
        tick();

        // Simultaneous mthi/mtlo, then reset in the middle of a multiply.
        applyStimulus(0, OP_MULT, 32'hAAAA5555, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idleAll();
        checkOutput("mthi_mtlo", hiloOf(0), 64'hAAAA5555_AAAA5555);
        applyStimulus(0, OP_MULT, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idleAll();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("async_rst_busy", 64'(m1.busy), 64'h0);
        checkOutput("async_rst_hilo", hiloOf(0), 64'h0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        checkOutput("post_rst_hilo", hiloOf(0), 64'h0);
        checkOutput("post_rst_busy", 64'(m1.busy), 64'h0);

        runOp("mult_neg", 0, OP_MULT, 32'hFFFFFFFE, 32'd3, 5, 64'hFFFFFFFF_FFFFFFFA);
        runOp("multu", 0, OP_MULTU, 32'hFFFFFFFE, 32'd3, 5, 64'h00000002_FFFFFFFA);
        runOp("div_neg", 0, OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 64'hFFFFFFFF_FFFFFFFD);
        runOp("divu_zero", 0, OP_DIVU, 32'd7, 32'd0, 10, 64'h00000007_FFFFFFFF);
        runOp("div_zero", 0, OP_DIV, 32'hFFFFFFFB, 32'd0, 10, 64'hFFFFFFFB_FFFFFFFF);
        runOp("div_ovf", 0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 64'h00000000_80000000);
        runOp("divu_big", 0, OP_DIVU, 32'hFFFFFFF9, 32'd2, 10, 64'h00000001_7FFFFFFC);

        // Accumulate chain across the HI/LO word boundary.
        applyStimulus(0, OP_MULT, 32'd1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(0, OP_MULT, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idleAll();
        checkOutput("mthi_then_mtlo", hiloOf(0), 64'h00000001_FFFFFFFF);
        runOp("maddu", 0, OP_MADDU, 32'd1, 32'd1, 5, 64'h00000002_00000000);
        runOp("msub", 0, OP_MSUB, 32'd1, 32'd1, 5, 64'h00000001_FFFFFFFF);
        runOp("madd_neg", 0, OP_MADD, 32'hFFFFFFFF, 32'd1, 5, 64'h00000001_FFFFFFFE);
        runOp("msubu", 0, OP_MSUBU, 32'hFFFFFFFF, 32'd2, 5, 64'h0);

        // Cancel on the second busy cycle, then start+cancel together in IDLE.
        applyStimulus(0, OP_MULT, 32'h11, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(0, OP_MULT, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idleAll();
        tick();
        checkOutput("cancel_pre_busy", 64'(m1.busy), 64'h1);
        applyStimulus(0, OP_MULT, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idleAll();
        checkOutput("cancel_busy", 64'(m1.busy), 64'h0);
        checkOutput("cancel_hilo", hiloOf(0), 64'h00000011_00000011);
        repeat (6) tick();
        checkOutput("cancel_no_commit", hiloOf(0), 64'h00000011_00000011);
        applyStimulus(0, OP_MULT, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idleAll();
        checkOutput("start_cancel_busy", 64'(m1.busy), 64'h0);
        repeat (6) tick();
        checkOutput("start_cancel_hilo", hiloOf(0), 64'h00000011_00000011);

        // start and mtlo during RUN are ignored; the original product commits.
        applyStimulus(0, OP_MULT, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n = 0;
        if (m1.busy) n++;
        applyStimulus(0, OP_MULT, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        if (m1.busy) n++;
        applyStimulus(0, OP_MULT, 32'd5, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idleAll();
        for (int i = 0; i < 40 && m1.busy; i++) begin
            n++;
            tick();
        end
        checkOutput("run_ignore_busy", 64'(n), 64'd5);
        checkOutput("run_ignore_hilo", hiloOf(0), 64'h00000000_0000001E);
        tick();
        checkOutput("start_not_queued", 64'(m1.busy), 64'h0);

        // start beats mthi in IDLE; the following madd sees the committed value.
        applyStimulus(0, OP_MULT, 32'd2, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idleAll();
        checkOutput("start_wins_we", hiloOf(0), 64'h00000000_0000001E);
        n = 0;
        for (int i = 0; i < 40 && m1.busy; i++) begin
            n++;
            tick();
        end
        checkOutput("start_wins_busy", 64'(n), 64'd5);
        checkOutput("start_wins_hilo", hiloOf(0), 64'h00000000_00000004);
        runOp("madd_b2b", 0, OP_MADD, 32'd1, 32'd1, 5, 64'h00000000_00000005);

        // 16-bit instance with single-cycle multiply.
        applyStimulus(1, OP_MULT, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("w16_busy", 64'(m2.busy), 64'h1);
        applyStimulus(1, OP_MULT, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idleAll();
        checkOutput("w16_done_busy", 64'(m2.busy), 64'h0);
        checkOutput("w16_mult", hiloOf(1), 64'h1);
        tick();
        checkOutput("w16_not_queued", 64'(m2.busy), 64'h0);
        runOp("w16_madd", 1, OP_MADD, 32'd2, 32'd3, 1, 64'h7);
        runOp("w16_msubu", 1, OP_MSUBU, 32'hFFFF, 32'd1, 1, 64'hFFFF0008);
        runOp("w16_div_ovf", 1, OP_DIV, 32'h8000, 32'hFFFF, 10, 64'h8000);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
